product_accum_32: RTL

Streaming accumulator that sits directly downstream of the 16x16 unsigned multiplier. It consumes the 32-bit products one per cycle over a valid/ready handshake and sums a frame of products delimited by `in_last`. It emits each frame's sum, product count and an overflow flag over a second valid/ready handshake. It is the reduction stage for dot-product and FIR-style use of the multiplier.

---
 rtl/product_accum_32.sv | 81 ++++++++
 1 files changed

// File: rtl/product_accum_32.sv
// Frame accumulator for 32-bit multiplier products with a valid/ready result port.
// Optional PRODUCT_ACCUM_SAT_EN clamps the accumulator on overflow instead of wrapping.
module product_accum_32 #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             beat;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] sum_next;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  // In HOLD a new beat may only enter in the same cycle the pending result leaves.
  assign in_ready  = (state == ST_ACCUM) | out_ready;
  assign out_valid = (state == ST_HOLD);
  assign beat      = in_valid & in_ready;

  always_comb begin
    sum_ext = {1'b0, acc} + {{(ACC_W + 1 - 32){1'b0}}, in_product};
    carry   = sum_ext[ACC_W];
`ifdef PRODUCT_ACCUM_SAT_EN
    sum_next = carry ? '1 : sum_ext[ACC_W-1:0];
`else
    sum_next = sum_ext[ACC_W-1:0];
`endif
    cnt_next = (&cnt) ? cnt : cnt + CNT_W'(1);
    ovf_next = ovf | carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (beat) begin
      if (in_last) begin
        out_sum   <= sum_next;
        out_count <= cnt_next;
        out_ovf   <= ovf_next;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
        state     <= ST_HOLD;
      end else begin
        acc   <= sum_next;
        cnt   <= cnt_next;
        ovf   <= ovf_next;
        state <= ST_ACCUM;
      end
    end else if (out_valid && out_ready) begin
      state <= ST_ACCUM;
    end
  end

endmodule
